// File: rtl/div_8bit.sv
// Sequential unsigned 16/8 restoring divider: 8-bit quotient and remainder, start/valid handshake.
// Optional macro DIV_8BIT_REGOUT_EN adds one output register stage (latency +1).
//
// state | meaning
// IDLE  | waiting for start; operands captured on accept
// CALC  | one restoring shift/subtract step per cycle, 8 steps
// DONE  | load quotient/remainder into the output registers
// ERR   | load divide-by-zero / overflow result into the output registers
module div_8bit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [7:0]  b,
    output logic        busy,
    output logic        valid,
    output logic [7:0]  q,
    output logic [7:0]  r,
    output logic        err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    logic [1:0] state_q, state_d;
    logic [7:0] rem_q, rem_d;
    logic [7:0] quo_q, quo_d;
    logic [7:0] div_q, div_d;
    logic [2:0] cnt_q, cnt_d;

    logic [7:0] q_q, q_d;
    logic [7:0] r_q, r_d;
    logic       err_q, err_d;
    logic       valid_q, valid_d;

    logic [8:0] rem_sh;
    logic       trial_ok;
    logic [7:0] trial_rem;
    logic       accept_ok;

    // The working remainder stays below the divisor, so its shifted value fits 9 bits
    // and a successful trial difference always fits back into 8 bits.
    assign rem_sh    = {rem_q, quo_q[7]};
    assign trial_ok  = (rem_sh >= {1'b0, div_q});
    assign trial_rem = rem_sh[7:0] - div_q;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        err_d   = err_q;
        valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && accept_ok) begin
                    div_d = b;
                    rem_d = a[15:8];
                    quo_d = a[7:0];
                    cnt_d = 3'd7;
                    if ((b == 8'h00) || (a[15:8] >= b)) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                rem_d = trial_ok ? trial_rem : rem_sh[7:0];
                quo_d = {quo_q[6:0], trial_ok};
                if (cnt_q == 3'd0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_DONE: begin
                q_d     = quo_q;
                r_d     = rem_q;
                err_d   = 1'b0;
                valid_d = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                q_d     = 8'hFF;
                r_d     = 8'h00;
                err_d   = 1'b1;
                valid_d = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rem_q   <= 8'h00;
            quo_q   <= 8'h00;
            div_q   <= 8'h00;
            cnt_q   <= 3'd0;
            q_q     <= 8'h00;
            r_q     <= 8'h00;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            err_q   <= err_d;
            valid_q <= valid_d;
        end
    end

`ifdef DIV_8BIT_REGOUT_EN
    logic [7:0] q2_q, q2_d;
    logic [7:0] r2_q, r2_d;
    logic       err2_q, err2_d;
    logic       valid2_q, valid2_d;

    always_comb begin
        q2_d     = valid_q ? q_q : q2_q;
        r2_d     = valid_q ? r_q : r2_q;
        err2_d   = valid_q ? err_q : err2_q;
        valid2_d = valid_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q2_q     <= 8'h00;
            r2_q     <= 8'h00;
            err2_q   <= 1'b0;
            valid2_q <= 1'b0;
        end else begin
            q2_q     <= q2_d;
            r2_q     <= r2_d;
            err2_q   <= err2_d;
            valid2_q <= valid2_d;
        end
    end

    // A result still in the pipeline stage keeps the block from accepting.
    assign accept_ok = ~valid_q;
    assign busy      = (state_q != S_IDLE) | valid_q | valid2_q;
    assign valid     = valid2_q;
    assign q         = q2_q;
    assign r         = r2_q;
    assign err       = err2_q;
`else
    assign accept_ok = 1'b1;
    assign busy      = (state_q != S_IDLE) | valid_q;
    assign valid     = valid_q;
    assign q         = q_q;
    assign r         = r_q;
    assign err       = err_q;
`endif

endmodule

// File: tb/tb_div_8bit.sv
// Directed self-checking bench for div_8bit: reset, nominal/boundary divides, error cases,
// start collision while busy, and reset during an operation.
module tb_div_8bit;

`ifdef DIV_8BIT_REGOUT_EN
    localparam int LAT_N  = 10;
    localparam int LAT_E  = 2;
    localparam int PERIOD = 11;
`else
    localparam int LAT_N  = 9;
    localparam int LAT_E  = 1;
    localparam int PERIOD = 10;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [7:0]  b;
    logic        busy;
    logic        valid;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        err;

    int errors = 0;
    int checks = 0;

    div_8bit dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .valid (valid),
        .q     (q),
        .r     (r),
        .err   (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; a = 16'h03E8; b = 8'h07;
        repeat (3) tick();
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
        checks++; if (q !== 8'h00)    begin errors++; $display("FAIL reset_q got %h want 00", q); end
        checks++; if (r !== 8'h00)    begin errors++; $display("FAIL reset_r got %h want 00", r); end
        checks++; if (err !== 1'b0)   begin errors++; $display("FAIL reset_err got %b want 0", err); end
        rst = 1'b0; start = 1'b0;
        tick();
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL post_reset_busy got %b want 0", busy); end
    endtask

    // Issues one start pulse from idle and checks latency, busy window, result and hold.
    task automatic do_op(input logic [15:0] ta, input logic [7:0] tb_in, input logic [7:0] eq,
                         input logic [7:0] er, input logic ee, input int elat, input string name);
        int  n;
        bit  seen;
        bit  busy_ok;
        a = ta; b = tb_in; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0; seen = 1'b0; busy_ok = 1'b1;
        while (!seen && n < 40) begin
            if (valid === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (busy !== 1'b1) busy_ok = 1'b0;
                tick();
                n++;
            end
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL %s timeout: no valid within 40 cycles", name);
        end else begin
            checks++; if (n != elat) begin errors++; $display("FAIL %s latency got %0d want %0d", name, n, elat); end
            checks++; if (q !== eq) begin errors++; $display("FAIL %s q got %h want %h", name, q, eq); end
            checks++; if (r !== er) begin errors++; $display("FAIL %s r got %h want %h", name, r, er); end
            checks++; if (err !== ee) begin errors++; $display("FAIL %s err got %b want %b", name, err, ee); end
            checks++; if (!busy_ok || busy !== 1'b1) begin errors++; $display("FAIL %s busy_window got %b want 1", name, busy); end
            tick();
            checks++; if (valid !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL %s valid/busy_after got %b/%b want 0/0", name, valid, busy);
            end
            checks++; if (q !== eq || r !== er || err !== ee) begin
                errors++; $display("FAIL %s hold got %h/%h/%b want %h/%h/%b", name, q, r, err, eq, er, ee);
            end
        end
    endtask

    task automatic test_nominal();
        do_op(16'h03E8, 8'h07, 8'h8E, 8'h06, 1'b0, LAT_N, "nominal");
    endtask

    task automatic test_boundaries();
        do_op(16'hFEFF, 8'hFF, 8'hFF, 8'hFE, 1'b0, LAT_N, "max_legal");
        do_op(16'h0000, 8'h35, 8'h00, 8'h00, 1'b0, LAT_N, "zero_dividend");
        do_op(16'h0AFF, 8'h0B, 8'hFF, 8'h0A, 1'b0, LAT_N, "hi_just_below_b");
        do_op(16'h1234, 8'h56, 8'h36, 8'h10, 1'b0, LAT_N, "mid_value");
        do_op(16'h7FFF, 8'h80, 8'hFF, 8'h7F, 1'b0, LAT_N, "pow2_divisor");
    endtask

    task automatic test_errors();
        do_op(16'h1234, 8'h00, 8'hFF, 8'h00, 1'b1, LAT_E, "div_by_zero");
        do_op(16'h0000, 8'h00, 8'hFF, 8'h00, 1'b1, LAT_E, "zero_by_zero");
        do_op(16'h0100, 8'h01, 8'hFF, 8'h00, 1'b1, LAT_E, "overflow_min");
        do_op(16'h5000, 8'h50, 8'hFF, 8'h00, 1'b1, LAT_E, "overflow_equal");
        do_op(16'hFFFF, 8'hFF, 8'hFF, 8'h00, 1'b1, LAT_E, "overflow_max");
    endtask

    function automatic logic [15:0] coll_a(input int e);
        logic [7:0] lo;
        lo = 8'(e * 7);
        return {8'h10, lo};
    endfunction

    function automatic logic [7:0] coll_b(input int e);
        return 8'h40 + 8'(e);
    endfunction

    // start held high with operands changing every cycle; only IDLE captures count.
    task automatic test_back_to_back();
        int nres;
        int last_e;
        int acc;
        logic [15:0] xa;
        logic [7:0]  xb;
        logic [7:0]  eq;
        logic [7:0]  er;
        nres = 0; last_e = -100;
        a = coll_a(0); b = coll_b(0); start = 1'b1;
        for (int e = 0; e < 45 && nres < 3; e++) begin
            tick();
            if (valid === 1'b1) begin
                acc = nres * PERIOD;
                xa = coll_a(acc); xb = coll_b(acc);
                eq = 8'(xa / {8'h00, xb});
                er = 8'(xa % {8'h00, xb});
                checks++; if (e != acc + LAT_N) begin errors++; $display("FAIL b2b_timing[%0d] got edge %0d want %0d", nres, e, acc + LAT_N); end
                checks++; if (e - last_e < 10) begin errors++; $display("FAIL b2b_spacing[%0d] got %0d want >=10", nres, e - last_e); end
                checks++; if (q !== eq || r !== er || err !== 1'b0) begin
                    errors++; $display("FAIL b2b_result[%0d] got %h/%h/%b want %h/%h/0", nres, q, r, err, eq, er);
                end
                nres++; last_e = e;
            end
            a = coll_a(e + 1); b = coll_b(e + 1);
        end
        start = 1'b0;
        checks++; if (nres < 3) begin errors++; $display("FAIL b2b_count got %0d want 3", nres); end
        for (int i = 0; i < 30 && busy !== 1'b0; i++) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_drain busy got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        bit stray;
        a = 16'h1234; b = 8'h56; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", valid); end
        checks++; if (q !== 8'h00 || r !== 8'h00) begin errors++; $display("FAIL midrst_qr got %h/%h want 00/00", q, r); end
        checks++; if (err !== 1'b0)   begin errors++; $display("FAIL midrst_err got %b want 0", err); end
        stray = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (valid !== 1'b0 || busy !== 1'b0) stray = 1'b1;
        end
        checks++; if (stray) begin errors++; $display("FAIL midrst_stray got activity want none"); end
        do_op(16'h0064, 8'h0A, 8'h0A, 8'h00, 1'b0, LAT_N, "after_reset");
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = 16'h0000; b = 8'h00;
        test_reset();
        test_nominal();
        test_boundaries();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
